// File: rtl/lut_eval.sv
// -----------------------------------------------------------------------------
// lut_eval
//   Registered truth-table evaluator. Each of N_CH channels holds a
//   2^N_IN-bit table, and the current input vector indexes every table in
//   parallel. New tables are shifted serially into a shadow buffer. They are
//   copied into the active tables in a single edge, so evaluation never stalls
//   and never sees a half-written table.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   cfg_start  in   begin (or restart) a table load
//   cfg_valid  in   cfg_bit is valid this cycle
//   cfg_bit    in   serial table bit; order is channel 0 first, address 0 first
//   cfg_busy   out  load in progress
//   cfg_done   out  one-cycle pulse after the new tables are committed
//   in_valid   in   in_vars valid this cycle
//   in_vars    in   table address, MSB = bit N_IN-1
//   out_valid  out  out_f updated (in_valid delayed by one cycle)
//   out_f      out  function results, bit c = channel c
// -----------------------------------------------------------------------------
module lut_eval #(
  parameter int N_IN = 4,
  parameter int N_CH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vars,
  output logic            out_valid,
  output logic [N_CH-1:0] out_f
);

  localparam int DEPTH = 1 << N_IN;
  localparam int TOT   = N_CH * DEPTH;
  // TOT is a power-of-two multiple of DEPTH >= 4, so its last index fits here.
  localparam int CNT_W = $clog2(TOT);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [TOT-1:0]             r_shadow, w_shadow_nxt;
  // Packed so that flat bit c*DEPTH+addr is r_active[c][addr].
  logic [N_CH-1:0][DEPTH-1:0] r_active;
  logic                       w_last;
  logic                       r_done;
  logic                       r_vld_p1;
  logic [N_CH-1:0]            r_out_f_p1;
  logic [N_CH-1:0]            w_eval;

  // Load FSM. cfg_start has priority over cfg_valid in every state, so a bit
  // presented with the start pulse is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_last       = 1'b0;
    case (r_state)
      RUN: begin
        if (cfg_start) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          w_cnt_nxt = '0;
        end else if (cfg_valid) begin
          w_shadow_nxt[r_cnt] = cfg_bit;
          if (r_cnt == CNT_W'(TOT - 1)) begin
            w_last      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      // The commit copies the shadow together with the bit that arrives on
      // this same edge.
      if (w_last) begin
        r_active <= w_shadow_nxt;
      end
      r_done <= w_last;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      assign w_eval[g] = r_active[g][in_vars];
    end
  endgenerate

  // ---- stage p0 -> p1: registered lookup --------------------------------
  // Reads the table as it was before this edge, so an evaluation that lands
  // on the commit edge still sees the old function.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_out_f_p1 <= '0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_out_f_p1 <= w_eval;
      end
    end
  end

  assign cfg_busy  = (r_state == LOAD);
  assign cfg_done  = r_done;
  assign out_valid = r_vld_p1;
  assign out_f     = r_out_f_p1;

endmodule

// File: doc/lut_eval.md
# lut_eval

Parametrised, registered truth-table evaluator: N_CH independent Boolean functions of N_IN input variables, each stored as a 2^N_IN-bit table.
- Tables are loaded serially at run time through a shadow buffer and committed atomically, so evaluation is never interrupted.
- Generalises the fixed two-mux, 4-variable function block: variable count, channel count and table contents are no longer hard-wired.
- Sits between switch/GPIO input logic and downstream control in lab top levels.

## Interface
Parameters:
- N_IN, 4, number of input variables; table depth DEPTH = 2^N_IN (legal 2..8)
- N_CH, 2, number of independent functions (legal 1..8)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  begin a table load (one-cycle pulse)
- cfg_valid  in  1  cfg_bit is valid this cycle
- cfg_bit  in  1  serial table bit
- cfg_busy  out  1  load in progress
- cfg_done  out  1  one-cycle pulse: new tables committed
- in_valid  in  1  in_vars valid this cycle
- in_vars  in  N_IN  variable vector; bit N_IN-1 is the MSB of the table address
- out_valid  out  1  out_f valid
- out_f  out  N_CH  function results; bit c = channel c

One clock; reset is asynchronous and active-low.

## Operation
- Storage:
  - active table: N_CH*DEPTH bits.
  - shadow table: same size.
  - load counter cnt: width clog2(N_CH*DEPTH), plus 1 bit if required to hold the final index.
- FSM states:
  - RUN: reset state.
    - cfg_start=1 -> LOAD, cnt<=0.
    - cfg_valid without a preceding cfg_start is ignored.
  - LOAD:
    - Each cycle with cfg_valid=1: shadow[cnt]<=cfg_bit, cnt<=cnt+1.
    - Bit index k = c*DEPTH + addr, so channel 0 comes first and address 0 comes first within each channel.
    - Accepting bit N_CH*DEPTH-1: active<=shadow (with the final bit included) on that edge, -> RUN.
- Restart: cfg_start in LOAD resets cnt to 0 and stays in LOAD. Shadow content is discarded logically; the active table is untouched.
- Priority: cfg_start and cfg_valid in the same cycle -> cfg_start wins and cfg_bit is ignored. This applies in both RUN and LOAD.
- cfg_busy = (state==LOAD).
- Evaluation runs in both states and always uses the active table:
  - out_f[c] <= active[c*DEPTH + in_vars] when in_valid=1.
  - out_f holds its previous value when in_valid=0.
- A partial load never affects out_f.
- No backpressure; every in_valid is accepted.

## Timing
- Reset values: out_f=0, out_valid=0, cfg_busy=0, cfg_done=0, active=0, shadow=0, cnt=0, state=RUN.
- Evaluation latency is 1 cycle: in_valid at edge n gives out_valid=1 and out_f after edge n. out_valid follows in_valid delayed by exactly 1 cycle, so back-to-back inputs give back-to-back outputs.
- cfg_busy rises the cycle after cfg_start and falls the cycle after the last bit is accepted.
- cfg_done is registered: high for exactly the one cycle after the commit edge.
- Boundary at commit:
  - An evaluation sampled on the commit edge reads the old table.
  - The first evaluation sampled on the next edge reads the new table.
- A full load with continuous cfg_valid takes N_CH*DEPTH cycles after cfg_start. Gaps in cfg_valid only stretch the load.
- Reset asserted mid-load aborts the load and clears both tables; outputs go to their reset values immediately (asynchronous).

## Test plan
- Reset, then in_valid with in_vars=4'hF -> out_valid=1 one cycle later, out_f=2'b00.
- Load ch0=16'hDE2F, ch1=16'h8001 (32 bits, continuous cfg_valid) -> cfg_busy high for 32 cycles, cfg_done pulses once. Then:
  - in_vars 4'h0 -> 2'b11
  - 4'h4 -> 2'b00
  - 4'h5 -> 2'b01
  - 4'hF -> 2'b11
- Stream in_vars 0..15 back-to-back during a second load (ch0=16'h0000, ch1=16'hFFFF) -> all results use the old tables. Evaluations from the cycle after commit return 2'b10.
- Load with cfg_valid toggled every other cycle, plus cfg_start re-issued after 10 bits -> committed table equals only the 32 bits sent after the restart. cfg_done fires once.
- cfg_start with cfg_valid=1 and cfg_bit=1 in the same cycle -> that bit is not stored; the load still needs 32 further bits.
- rst_n low after 20 of 32 load bits -> cfg_busy=0 and out_f=0. A following evaluation of 4'h0 returns 2'b00 and no cfg_done appears.
